// File: rtl/toggle_count_ctrl_pkg.sv
// Shared definitions for the toggle-count controller.
//   state_t      : controller FSM encoding (IDLE / RUN / DONE)
//   UP / DOWN    : values of the up_dn input
//   FREE/ONESHOT : values of the mode input
package toggle_count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic UP      = 1'b1;
  localparam logic DOWN    = 1'b0;
  localparam logic FREE    = 1'b0;
  localparam logic ONESHOT = 1'b1;

endpackage

// File: rtl/toggle_count_ctrl_t_ff_cell.sv
// Single T flip-flop storage bit, built from a D flip-flop with D = Q ^ T.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears Q
//   t     : toggle enable
//   q     : stored bit
//   qb    : complement of q
module t_ff_cell (
  input  logic clock,
  input  logic reset,
  input  logic t,
  output logic q,
  output logic qb
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= q ^ t;
  end

  assign qb = ~q;

endmodule

// File: rtl/toggle_count_ctrl.sv
// Programmable modulo counter built on a bank of T flip-flops.  The controller
// works out the next count each cycle and drives the bank with
// t_vec = count ^ next_count.
// Ports:
//   clock, reset        : system clock, asynchronous active-low reset
//   start / stop        : run handshake (start sampled in IDLE, stop in RUN)
//   up_dn               : 1 = up, 0 = down, applies to the current step
//   mode                : 0 = free-run wrap, 1 = one-shot halt at terminal
//   load / load_val     : preset in IDLE, clamped to MAX_COUNT
//   count               : Q of the T flip-flop bank
//   t_vec               : T enables applied this cycle
//   busy / tc / done    : running, at terminal value, one-shot completion pulse
//
// state | meaning
// IDLE  | waiting for start; load may preset the count
// RUN   | stepping the count once per cycle
// DONE  | one-shot reached terminal; single-cycle done pulse
module toggle_count_ctrl
  import toggle_count_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb_unused;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] t_int;
  logic             at_term;

  always_comb begin
    target     = (load_val > MAX_V) ? MAX_V : load_val;
    term_val   = (up_dn == UP) ? MAX_V : '0;
    at_term    = (state == RUN) && (q == term_val);
    next_count = q;
    case (state)
      IDLE: begin
        if (load) next_count = target;
      end
      RUN: begin
        // stop wins over both stepping and terminal handling
        if (!stop) begin
          if (at_term) begin
            if (mode == FREE) next_count = (up_dn == UP) ? '0 : MAX_V;
          end else begin
            next_count = (up_dn == UP) ? q + 1'b1 : q - 1'b1;
          end
        end
      end
      default: next_count = q;
    endcase
  end

  assign t_int = q ^ next_count;
  // Keep the visible enables quiet while reset is asserted, even if load is high.
  assign t_vec = reset ? t_int : '0;
  assign tc    = at_term;
  assign count = q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    t_ff_cell u_cell (
      .clock (clock),
      .reset (reset),
      .t     (t_int[i]),
      .q     (q[i]),
      .qb    (qb_unused[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (at_term && (mode == ONESHOT)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
